// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types, RTC register map and read-index mapping
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_CAPTURE,
        ST_WR_REQ,
        ST_WR_ACK
    } rtc_state_e;

    localparam logic [7:0] RTC_ADDR_SEC     = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN     = 8'h22;
    localparam logic [7:0] RTC_ADDR_HOUR    = 8'h23;
    localparam logic [7:0] RTC_ADDR_WDAY    = 8'h24;
    localparam logic [7:0] RTC_ADDR_DAY     = 8'h25;
    localparam logic [7:0] RTC_ADDR_MONTH   = 8'h26;
    localparam logic [7:0] RTC_ADDR_YEAR    = 8'h27;
    localparam logic [7:0] RTC_ADDR_CENT    = 8'h28;
    localparam logic [7:0] RTC_ADDR_CRONO_S = 8'h41;
    localparam logic [7:0] RTC_ADDR_CRONO_M = 8'h42;
    localparam logic [7:0] RTC_ADDR_CRONO_H = 8'h43;

    localparam int NUM_DISPLAY_REGS = 11;
    localparam int IDX_W            = 4;

    function automatic logic [7:0] rtc_read_addr(input logic [IDX_W-1:0] index);
        case (index)
            4'd0:    return RTC_ADDR_SEC;
            4'd1:    return RTC_ADDR_MIN;
            4'd2:    return RTC_ADDR_HOUR;
            4'd3:    return RTC_ADDR_WDAY;
            4'd4:    return RTC_ADDR_DAY;
            4'd5:    return RTC_ADDR_MONTH;
            4'd6:    return RTC_ADDR_YEAR;
            4'd7:    return RTC_ADDR_CENT;
            4'd8:    return RTC_ADDR_CRONO_S;
            4'd9:    return RTC_ADDR_CRONO_M;
            4'd10:   return RTC_ADDR_CRONO_H;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rtc_access_scheduler_if.sv
// rtl/rtc_access_scheduler_if.sv - RTC bus, user write and capture signals (bus_error with RTC_SCHED_TIMEOUT_EN)
interface rtc_access_scheduler_if;

    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic [7:0] capture_addr;
    logic [7:0] capture_data;
    logic       capture_valid;
    logic       sweep_done;
`ifdef RTC_SCHED_TIMEOUT_EN
    logic       bus_error;
`endif

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, wr_done,
               capture_addr, capture_data, capture_valid, sweep_done,
`ifdef RTC_SCHED_TIMEOUT_EN
        output bus_error,
`endif
        input  bus_ack, bus_rdata, wr_req, wr_addr, wr_data
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, wr_done,
               capture_addr, capture_data, capture_valid, sweep_done,
`ifdef RTC_SCHED_TIMEOUT_EN
        input  bus_error,
`endif
        output bus_ack, bus_rdata, wr_req, wr_addr, wr_data
    );

endinterface

// File: rtl/rtc_refresh_timer.sv
// rtl/rtc_refresh_timer.sv - free-running down-counter producing the sweep tick
module rtc_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned    CNT_W  = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == '0) ? RELOAD : count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == '0);

endmodule

// File: rtl/rtc_access_scheduler.sv
// rtl/rtc_access_scheduler.sv - RTC bus sequencer: display refresh sweeps plus user writes (watchdog: RTC_SCHED_TIMEOUT_EN)
module rtc_access_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    rtc_access_scheduler_if.master  rtc_if
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DISPLAY_REGS - 1);

    if (REFRESH_CYCLES < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("rtc_access_scheduler: REFRESH_CYCLES must be >= 16 and TIMEOUT_CYCLES >= 1");
    end

    rtc_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_next;
    logic             pending_q;
    logic             pending_d;
    logic             refresh_tick;
    logic             start_sweep;

    logic             bus_req_q;
    logic             bus_we_q;
    logic [7:0]       bus_addr_q;
    logic [7:0]       bus_wdata_q;
    logic             wr_done_q;
    logic [7:0]       cap_addr_q;
    logic [7:0]       cap_data_q;
    logic             cap_valid_q;
    logic             sweep_done_q;

`ifdef RTC_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            bus_error_q;
    logic            timeout;

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    rtc_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .reset  (reset),
        .tick_o (refresh_tick)
    );

    // A tick landing while a sweep is already owed merges into the same request.
    assign start_sweep = (state_q == ST_IDLE) && !rtc_if.wr_req &&
                         (pending_q || refresh_tick) && (idx_q == '0);
    assign idx_next    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        pending_d = pending_q | refresh_tick;
        if (start_sweep) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 8'h00;
            bus_wdata_q  <= 8'h00;
            wr_done_q    <= 1'b0;
            cap_addr_q   <= 8'h00;
            cap_data_q   <= 8'h00;
            cap_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
`ifdef RTC_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
`ifdef RTC_SCHED_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    if (rtc_if.wr_req) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= rtc_if.wr_addr;
                        bus_wdata_q <= rtc_if.wr_data;
                        state_q     <= ST_WR_REQ;
                    end else if (pending_q || refresh_tick || idx_q != '0) begin
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= rtc_read_addr(idx_q);
                        state_q    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (rtc_if.bus_ack) begin
                        bus_req_q    <= 1'b0;
                        cap_valid_q  <= 1'b1;
                        cap_addr_q   <= rtc_read_addr(idx_q);
                        cap_data_q   <= rtc_if.bus_rdata;
                        sweep_done_q <= (idx_q == LAST_IDX);
                        state_q      <= ST_CAPTURE;
                    end
`ifdef RTC_SCHED_TIMEOUT_EN
                    else if (timeout) begin
                        // Lost read: skip the register and keep the sweep moving.
                        bus_req_q   <= 1'b0;
                        bus_error_q <= 1'b1;
                        idx_q       <= idx_next;
                        state_q     <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_CAPTURE: begin
                    cap_valid_q  <= 1'b0;
                    cap_addr_q   <= 8'h00;
                    sweep_done_q <= 1'b0;
                    idx_q        <= idx_next;
                    state_q      <= ST_IDLE;
                end
                ST_WR_REQ: begin
                    if (rtc_if.bus_ack) begin
                        bus_req_q <= 1'b0;
                        wr_done_q <= 1'b1;
                        state_q   <= ST_WR_ACK;
                    end
`ifdef RTC_SCHED_TIMEOUT_EN
                    else if (timeout) begin
                        bus_req_q   <= 1'b0;
                        bus_error_q <= 1'b1;
                        wr_done_q   <= 1'b1;
                        state_q     <= ST_WR_ACK;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_WR_ACK: begin
                    wr_done_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rtc_if.bus_req       = bus_req_q;
    assign rtc_if.bus_we        = bus_we_q;
    assign rtc_if.bus_addr      = bus_addr_q;
    assign rtc_if.bus_wdata     = bus_wdata_q;
    assign rtc_if.wr_done       = wr_done_q;
    assign rtc_if.capture_addr  = cap_addr_q;
    assign rtc_if.capture_data  = cap_data_q;
    assign rtc_if.capture_valid = cap_valid_q;
    assign rtc_if.sweep_done    = sweep_done_q;
`ifdef RTC_SCHED_TIMEOUT_EN
    assign rtc_if.bus_error     = bus_error_q;
`endif

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// tb/tb_rtc_access_scheduler.sv - directed self-checking bench for rtc_access_scheduler
module tb_rtc_access_scheduler;

    localparam int REFRESH = 16;
    localparam int TIMEOUT = 8;
`ifdef RTC_SCHED_TIMEOUT_EN
    localparam int LONG_DELAY = 6;
`else
    localparam int LONG_DELAY = 30;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtc_access_scheduler_if bif();

    rtc_access_scheduler #(
        .REFRESH_CYCLES (REFRESH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rtc_if (bif)
    );

    logic       ack_drv = 1'b0;
    logic       ack_force = 1'b0;
    logic [7:0] rdata_drv = 8'h00;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;

    assign bif.bus_ack   = ack_drv | ack_force;
    assign bif.bus_rdata = rdata_drv;
    assign bif.wr_req    = wr_req;
    assign bif.wr_addr   = wr_addr;
    assign bif.wr_data   = wr_data;

    typedef struct {
        logic [7:0] rdata;
        logic [7:0] exp_addr;
        logic       exp_done;
        int         exp_cyc;
    } vec_t;
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       done;
        int         cyc;
    } cap_t;
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    vec_t       vecs [11];
    logic [7:0] rd_mem [256];
    cap_t       cap_q [$];
    txn_t       txn_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_delay = 1;
    int wait_cnt = 0;
    int wr_done_cnt = 0;
    int done_cnt = 0;
    logic [7:0] no_ack_addr = 8'h00;
    logic req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // RTC chip model: acks ack_delay cycles after req rises, never for no_ack_addr.
    always @(negedge clk) begin
        if (reset || !bif.bus_req) begin
            ack_drv  = 1'b0;
            wait_cnt = 0;
        end else if (ack_drv) begin
            ack_drv = 1'b0;
        end else if (!bif.bus_we && bif.bus_addr == no_ack_addr) begin
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            ack_drv   = 1'b1;
            rdata_drv = rd_mem[bif.bus_addr];
            wait_cnt  = 0;
        end else begin
            wait_cnt++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            req_prev = 1'b0;
        end else begin
            if (bif.capture_valid) begin
                cap_q.push_back('{bif.capture_addr, bif.capture_data, bif.sweep_done, cyc});
            end else begin
                check("idle_capture_addr", bif.capture_addr, 8'h00);
            end
            if (bif.sweep_done) done_cnt++;
            if (bif.wr_done) wr_done_cnt++;
            if (bif.bus_req && !req_prev) txn_q.push_back('{bif.bus_we, bif.bus_addr, bif.bus_wdata});
            req_prev = bif.bus_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int c0, d0, n0, n, cnt;
        logic found;

        vecs[0]  = '{8'hA0, 8'h21, 1'b0, 18};
        vecs[1]  = '{8'hA1, 8'h22, 1'b0, 22};
        vecs[2]  = '{8'hA2, 8'h23, 1'b0, 26};
        vecs[3]  = '{8'hA3, 8'h24, 1'b0, 30};
        vecs[4]  = '{8'hA4, 8'h25, 1'b0, 34};
        vecs[5]  = '{8'hA5, 8'h26, 1'b0, 38};
        vecs[6]  = '{8'hA6, 8'h27, 1'b0, 42};
        vecs[7]  = '{8'hA7, 8'h28, 1'b0, 46};
        vecs[8]  = '{8'hA8, 8'h41, 1'b0, 50};
        vecs[9]  = '{8'hA9, 8'h42, 1'b0, 54};
        vecs[10] = '{8'hAA, 8'h43, 1'b1, 58};
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
        for (int i = 0; i < 11; i++) rd_mem[vecs[i].exp_addr] = vecs[i].rdata;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_bus_req", bif.bus_req, 0);
        check("rst_bus_we", bif.bus_we, 0);
        check("rst_bus_addr", bif.bus_addr, 0);
        check("rst_bus_wdata", bif.bus_wdata, 0);
        check("rst_wr_done", bif.wr_done, 0);
        check("rst_capture_addr", bif.capture_addr, 0);
        check("rst_capture_data", bif.capture_data, 0);
        check("rst_capture_valid", bif.capture_valid, 0);
        check("rst_sweep_done", bif.sweep_done, 0);
`ifdef RTC_SCHED_TIMEOUT_EN
        check("rst_bus_error", bif.bus_error, 0);
`endif
        reset = 1'b0;

        // Stray ack while idle
        repeat (3) nxt();
        ack_force = 1'b1;
        nxt();
        ack_force = 1'b0;
        check("stray_ack_valid", bif.capture_valid, 0);
        check("stray_ack_addr", bif.capture_addr, 8'h00);
        check("stray_ack_req", bif.bus_req, 0);
        check("stray_ack_caps", cap_q.size(), 0);

        // First sweep
        while (!bif.bus_req && cyc < 100) nxt();
        check("first_req_cycle", cyc, REFRESH);
        check("first_req_addr", bif.bus_addr, 8'h21);
        check("first_req_we", bif.bus_we, 0);
        cnt = 0;
        while (cap_q.size() < 11 && cnt < 200) begin nxt(); cnt++; end
        check("sweep1_complete", cap_q.size() >= 11, 1);
        for (int i = 0; i < 11; i++) begin
            if (i < cap_q.size()) begin
                check($sformatf("sweep1_addr[%0d]", i), cap_q[i].addr, vecs[i].exp_addr);
                check($sformatf("sweep1_data[%0d]", i), cap_q[i].data, vecs[i].rdata);
                check($sformatf("sweep1_done[%0d]", i), cap_q[i].done, vecs[i].exp_done);
                check($sformatf("sweep1_cyc[%0d]", i), cap_q[i].cyc, vecs[i].exp_cyc);
            end
        end

        // User write during the 0x24 read
        found = 1'b0; cnt = 0;
        while (!found && cnt < 400) begin
            nxt(); cnt++;
            found = bif.bus_req && !bif.bus_we && bif.bus_addr == 8'h24;
        end
        check("wait_req_24", found, 1);
        n0 = txn_q.size();
        d0 = wr_done_cnt;
        wr_addr = 8'h21; wr_data = 8'h59; wr_req = 1'b1;
        cnt = 0;
        while (!bif.wr_done && cnt < 100) begin nxt(); cnt++; end
        check("wr_done_seen", bif.wr_done, 1);
        wr_req = 1'b0;
        cnt = 0;
        while (txn_q.size() < n0 + 2 && cnt < 100) begin nxt(); cnt++; end
        check("wr_txn_count", txn_q.size() >= n0 + 2, 1);
        if (txn_q.size() >= n0 + 2 && n0 > 0) begin
            check("wr_prev_addr", txn_q[n0-1].addr, 8'h24);
            check("wr_txn_we", txn_q[n0].we, 1);
            check("wr_txn_addr", txn_q[n0].addr, 8'h21);
            check("wr_txn_wdata", txn_q[n0].wdata, 8'h59);
            check("wr_after_we", txn_q[n0+1].we, 0);
            check("wr_after_addr", txn_q[n0+1].addr, 8'h25);
        end
        check("wr_done_pulses", wr_done_cnt - d0, 1);

        // Long acks: ticks merge into a single following sweep
        cnt = 0;
        while (!bif.sweep_done && cnt < 300) begin nxt(); cnt++; end
        check("wait_sweep_done", bif.sweep_done, 1);
        ack_delay = LONG_DELAY;
        c0 = cap_q.size();
        d0 = done_cnt;
        nxt();
        cnt = 0;
        while (!bif.sweep_done && cnt < 1000) begin nxt(); cnt++; end
        check("long_sweep_done", bif.sweep_done, 1);
        ack_delay = 1;
        check("long_caps", cap_q.size() - c0, 11);
        check("long_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < 11; i++) begin
            if (c0 + i < cap_q.size())
                check($sformatf("long_addr[%0d]", i), cap_q[c0+i].addr, vecs[i].exp_addr);
        end
        nxt();
        nxt();
        check("extra_sweep_req", bif.bus_req, 1);
        check("extra_sweep_addr", bif.bus_addr, 8'h21);

        // Reset in the middle of the 0x26 read
        found = 1'b0; cnt = 0;
        while (!found && cnt < 300) begin
            nxt(); cnt++;
            found = bif.bus_req && !bif.bus_we && bif.bus_addr == 8'h26;
        end
        check("wait_req_26", found, 1);
        reset = 1'b1;
        #1;
        check("reset_drops_req", bif.bus_req, 0);
        nxt();
        reset = 1'b0;
        cnt = 0;
        while (!bif.bus_req && cnt < 100) begin nxt(); cnt++; end
        check("restart_req_cycle", cyc, REFRESH);
        check("restart_addr", bif.bus_addr, 8'h21);

`ifdef RTC_SCHED_TIMEOUT_EN
        // Watchdog on an unanswered 0x23 read
        check("pre_timeout_error", bif.bus_error, 0);
        no_ack_addr = 8'h23;
        found = 1'b0; cnt = 0;
        while (!found && cnt < 100) begin
            nxt(); cnt++;
            found = bif.bus_req && bif.bus_addr == 8'h23;
        end
        check("wait_req_23", found, 1);
        c0 = cap_q.size();
        n = 0;
        while (bif.bus_req && n < 50) begin n++; nxt(); end
        check("timeout_req_len", n, TIMEOUT);
        check("timeout_error", bif.bus_error, 1);
        no_ack_addr = 8'h00;
        cnt = 0;
        while (cap_q.size() <= c0 && cnt < 100) begin nxt(); cnt++; end
        check("timeout_next_cap", cap_q.size() > c0, 1);
        if (cap_q.size() > c0) check("timeout_next_addr", cap_q[c0].addr, 8'h24);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
